icache_refill_controller: RTL and testbench

//   Sequences instruction-cache refills and invalidations for the fetch stage's cache port.
//   On a fetch miss it reads the 8-word line from the memory bus, then writes it with one cache_port_set pulse.
//   It also turns fence.i/sfence flush requests into cache_invalidate pulses.

---
 rtl/icache_refill_controller.sv | 94 +++++++++
 tb/tb_icache_refill_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_controller.sv
// icache_refill_controller: fetches 8-word lines on a miss and turns flush requests into cache invalidations
module icache_refill_controller #(
  parameter int VLEN         = 32,
  parameter int TIMEOUT_LOG2 = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                miss,
  input  logic [VLEN-6:0]     miss_vaddr,
  input  logic                pipe_stall,
  input  logic                redirect,
  input  logic                flush_req,
  input  logic                flush_selective,
  input  logic                flush_vaddr_top,
  output logic                flush_ack,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [VLEN-3:0]     mem_req_addr,
  input  logic                mem_rsp_valid,
  input  logic [31:0]         mem_rsp_data,
  input  logic                mem_rsp_err,
  output logic [VLEN-6:0]     cache_port_addr,
  output logic [7:0][31:0]    cache_port_data,
  output logic                cache_port_set,
  output logic                cache_invalidate,
  output logic                selective_invalidate,
  output logic                selective_invalidate_vaddr,
  output logic                refill_busy,
  output logic                fetch_fault
);
  typedef enum logic [2:0] {IDLE, REQ, RESP, WRITE, INVAL, ERR} state_t;
  state_t                  state, state_nx;
  logic [VLEN-6:0]         line;
  logic [2:0]              beat;
  logic [TIMEOUT_LOG2-1:0] watchdog;
  logic [7:0][31:0]        line_buf;

  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;

  // next state: flush beats miss in IDLE, a flush arriving mid-refill waits for the write
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = flush_req ? INVAL : miss ? REQ : IDLE;
      REQ:   state_nx = mem_req_ready ? RESP : REQ;
      RESP:  state_nx = mem_rsp_valid ? (mem_rsp_err ? ERR : beat == 3'd7 ? WRITE : REQ)
                                      : &watchdog ? ERR : RESP;
      WRITE: state_nx = pipe_stall ? WRITE : flush_req ? INVAL : IDLE;
      INVAL: state_nx = pipe_stall ? INVAL : IDLE;
      ERR:   state_nx = redirect ? IDLE : ERR;
      default: state_nx = IDLE;
    endcase
  end

  // line address capture, beat counter, response watchdog and line buffer
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      line     <= '0;
      beat     <= '0;
      watchdog <= '0;
      line_buf <= '0;
    end else begin
      if (state == IDLE && !flush_req && miss) begin
        line <= miss_vaddr;
        beat <= '0;
      end
      if (state == REQ && mem_req_ready) watchdog <= '0;
      if (state == RESP) begin
        watchdog <= watchdog + 1'b1;
        if (mem_rsp_valid && !mem_rsp_err) begin
          line_buf[beat] <= mem_rsp_data;
          beat           <= beat + 3'd1;
        end
      end
    end

  // outputs decoded from state; everything idles at zero
  always_comb begin
    mem_req_valid              = state == REQ;
    mem_req_addr               = mem_req_valid ? {line, beat} : '0;
    cache_port_set             = state == WRITE;
    cache_port_addr            = cache_port_set ? line : '0;
    cache_port_data            = cache_port_set ? line_buf : '0;
    cache_invalidate           = state == INVAL;
    selective_invalidate       = cache_invalidate & flush_selective;
    selective_invalidate_vaddr = cache_invalidate & flush_vaddr_top;
    flush_ack                  = cache_invalidate & ~pipe_stall;
    refill_busy                = state != IDLE;
    fetch_fault                = state == ERR;
  end
endmodule

// File: tb/tb_icache_refill_controller.sv
// tb_icache_refill_controller: directed vectors and refill sequences against a small bus responder
module tb_icache_refill_controller;
  localparam int VLEN = 32;
  logic clock = 0, reset_n = 0, miss = 0, pipe_stall = 0, redirect = 0;
  logic flush_req = 0, flush_selective = 0, flush_vaddr_top = 0;
  logic mem_req_ready = 0, mem_rsp_valid = 0, mem_rsp_err = 0;
  logic [26:0] miss_vaddr = 0;
  logic [31:0] mem_rsp_data = 0;
  logic flush_ack, mem_req_valid, cache_port_set, cache_invalidate;
  logic selective_invalidate, selective_invalidate_vaddr, refill_busy, fetch_fault;
  logic [29:0] mem_req_addr;
  logic [26:0] cache_port_addr;
  logic [7:0][31:0] cache_port_data;

  icache_refill_controller #(.VLEN(VLEN), .TIMEOUT_LOG2(10)) dut (
    .clock(clock), .reset_n(reset_n), .miss(miss), .miss_vaddr(miss_vaddr),
    .pipe_stall(pipe_stall), .redirect(redirect), .flush_req(flush_req),
    .flush_selective(flush_selective), .flush_vaddr_top(flush_vaddr_top),
    .flush_ack(flush_ack), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err), .cache_port_addr(cache_port_addr),
    .cache_port_data(cache_port_data), .cache_port_set(cache_port_set),
    .cache_invalidate(cache_invalidate), .selective_invalidate(selective_invalidate),
    .selective_invalidate_vaddr(selective_invalidate_vaddr), .refill_busy(refill_busy),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int gap_max = 0, err_beat = -1, cyc_n = 0;
  bit no_rsp = 0, pending = 0;
  int dly = 0;
  logic [29:0] cur_addr = 0;
  logic [29:0] addrs[$];
  int sets, busy_cnt, viol, overlap, acks, set_cyc, inval_first;
  logic [26:0] set_addr;
  logic [7:0][31:0] set_data;

  typedef struct {
    logic fr, fs, ft, ps, ms;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear();
    addrs.delete();
    sets = 0; busy_cnt = 0; viol = 0; overlap = 0; acks = 0;
    set_cyc = -1; inval_first = -1; cyc_n = 0; pending = 0; dly = 0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    cyc_n++;
    mem_req_ready = (gap_max == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    mem_rsp_valid = pending && dly == 0 && !no_rsp;
    mem_rsp_err   = mem_rsp_valid && int'(cur_addr[2:0]) == err_beat;
    mem_rsp_data  = mem_rsp_valid ? 32'h13 + 32'(cur_addr[2:0]) : 32'hdead_beef;
    #1;
    if (refill_busy) busy_cnt++;
    if (cache_port_set && cache_invalidate) overlap++;
    if (pending && mem_req_valid) viol++;
    if (cache_port_set && !pipe_stall) begin
      sets++; set_addr = cache_port_addr; set_data = cache_port_data; set_cyc = cyc_n;
    end
    if (cache_invalidate && inval_first < 0) inval_first = cyc_n;
    if (flush_ack) begin
      acks++;
      flush_req = 0;
    end
    if (mem_rsp_valid) pending = 0;
    else if (pending && dly > 0) dly--;
    if (mem_req_valid && mem_req_ready) begin
      addrs.push_back(mem_req_addr);
      cur_addr = mem_req_addr;
      pending  = 1;
      dly      = gap_max == 0 ? 0 : $urandom_range(0, gap_max);
    end
  endtask

  task automatic start_miss(input logic [26:0] ln);
    miss = 1; miss_vaddr = ln;
    cyc();
    miss = 0;
  endtask

  task automatic run_done(input int budget);
    int n = 0;
    while (!(sets > 0 && !refill_busy) && n < budget) begin
      cyc();
      n++;
    end
    chk("refill_done_in_budget", n < budget, 1);
  endtask

  task automatic chk_line(input string nm, input logic [26:0] ln);
    chk({nm, "_sets"}, sets, 1);
    chk({nm, "_set_addr"}, set_addr, ln);
    chk({nm, "_nreq"}, addrs.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_data%0d", nm, i), set_data[i], 32'h13 + i);
      if (i < addrs.size()) chk($sformatf("%s_addr%0d", nm, i), addrs[i], {ln, 3'(i)});
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {flush_ack, mem_req_valid, cache_port_set, cache_invalidate,
        selective_invalidate, selective_invalidate_vaddr, refill_busy, fetch_fault}, 0);
    chk({nm, "_req_addr"}, mem_req_addr, 0);
    chk({nm, "_port_addr"}, cache_port_addr, 0);
    chk({nm, "_port_data"}, |cache_port_data, 0);
  endtask

  initial begin
    vec_t v[12];
    int n;
    bit raised;
    v[0]  = '{0, 0, 0, 0, 0, 8'b0000_0000};
    v[1]  = '{1, 1, 1, 0, 0, 8'b0000_0000};
    v[2]  = '{1, 1, 1, 1, 0, 8'b1110_0001};
    v[3]  = '{1, 1, 1, 1, 0, 8'b1110_0001};
    v[4]  = '{1, 1, 1, 0, 0, 8'b1111_0001};
    v[5]  = '{0, 0, 0, 0, 0, 8'b0000_0000};
    v[6]  = '{1, 0, 1, 0, 0, 8'b0000_0000};
    v[7]  = '{1, 0, 1, 0, 0, 8'b1011_0001};
    v[8]  = '{0, 0, 0, 0, 0, 8'b0000_0000};
    v[9]  = '{1, 0, 0, 0, 1, 8'b0000_0000};
    v[10] = '{1, 0, 0, 0, 0, 8'b1001_0001};
    v[11] = '{0, 0, 0, 0, 0, 8'b0000_0000};

    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    @(negedge clock);
    reset_n = 1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      flush_req = v[i].fr; flush_selective = v[i].fs; flush_vaddr_top = v[i].ft;
      pipe_stall = v[i].ps; miss = v[i].ms; miss_vaddr = 27'h7;
      #1;
      chk($sformatf("vec%0d", i), {cache_invalidate, selective_invalidate,
          selective_invalidate_vaddr, flush_ack, cache_port_set, mem_req_valid,
          fetch_fault, refill_busy}, v[i].exp);
    end
    miss = 0; flush_req = 0; flush_selective = 0; flush_vaddr_top = 0; pipe_stall = 0;

    clear(); gap_max = 0;
    start_miss(27'h40);
    run_done(200);
    chk_line("t1", 27'h40);
    chk("t1_busy_cycles", busy_cnt, 17);

    clear(); gap_max = 5;
    start_miss(27'h40);
    run_done(400);
    chk_line("t2", 27'h40);
    chk("t2_req_while_resp", viol, 0);
    gap_max = 0;

    clear(); raised = 0; n = 0;
    start_miss(27'h1c);
    while (!(sets > 0 && acks > 0 && !refill_busy) && n < 300) begin
      cyc();
      n++;
      if (addrs.size() == 4 && !raised) begin
        flush_req = 1; raised = 1;
      end
    end
    chk("t4_in_budget", n < 300, 1);
    chk("t4_sets", sets, 1);
    chk("t4_set_addr", set_addr, 27'h1c);
    chk("t4_acks", acks, 1);
    chk("t4_inval_after_set", inval_first, set_cyc + 1);
    chk("t4_overlap", overlap, 0);

    clear(); err_beat = 5; n = 0;
    start_miss(27'h33);
    while (!fetch_fault && n < 200) begin cyc(); n++; end
    chk("t5_fault", fetch_fault, 1);
    chk("t5_nreq", addrs.size(), 6);
    repeat (3) cyc();
    chk("t5_fault_held", {fetch_fault, refill_busy}, 2'b11);
    chk("t5_no_set", sets, 0);
    redirect = 1;
    cyc();
    redirect = 0;
    chk("t5_cleared", {fetch_fault, refill_busy}, 2'b00);
    err_beat = -1;

    clear(); no_rsp = 1; n = 1;
    start_miss(27'h11);
    while (!fetch_fault && n < 1100) begin
      if (n == 1000) chk("t5_wd_not_early", fetch_fault, 0);
      cyc();
      n++;
    end
    chk("t5_wd_cycle", n, 1026);
    chk("t5_wd_no_set", sets, 0);
    redirect = 1;
    cyc();
    redirect = 0;
    chk("t5_wd_cleared", fetch_fault, 0);
    no_rsp = 0;

    clear(); n = 0;
    start_miss(27'h2a);
    while (!(addrs.size() == 5 && pending) && n < 100) begin cyc(); n++; end
    chk("t6_reach_beat4", addrs.size(), 5);
    @(posedge clock);
    #3;
    reset_n = 0;
    #1;
    chk_zero("t6_async");
    mem_rsp_valid = 0; mem_rsp_err = 0; pending = 0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    clear();
    start_miss(27'h55);
    run_done(200);
    chk_line("t6", 27'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
